// File: rtl/sram_fifo_pkg.sv
// Shared constants and helpers for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

  localparam int unsigned OBUF_DEPTH = 2;

  localparam string OBUF_OVF_MSG = "sram_fifo_obuf: capture into full output buffer";
  localparam string OBUF_UDF_MSG = "sram_fifo_obuf: pop from empty output buffer";

  typedef enum logic [1:0] {
    OBUF_EMPTY = 2'd0,
    OBUF_ONE   = 2'd1,
    OBUF_TWO   = 2'd2
  } obuf_lvl_e;

  // Occupancy spans 0..DEPTH+OBUF_DEPTH, so two bits beyond the address width.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry registered output buffer; the head drives the consumer directly from flops.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       cnt
);

  obuf_lvl_e        lvl_q, lvl_d;
  logic [WIDTH-1:0] head_q, tail_q;
  logic             load_head, load_tail, shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= OBUF_EMPTY;
    else        lvl_q <= lvl_d;
  end

  always_comb begin
    lvl_d     = lvl_q;
    load_head = '0;
    load_tail = '0;
    shift     = '0;
    case (lvl_q)
      OBUF_EMPTY: begin
        if (push) begin
          lvl_d     = OBUF_ONE;
          load_head = '1;
        end
      end
      OBUF_ONE: begin
        if (push && pop) begin
          load_head = '1;
        end else if (push) begin
          lvl_d     = OBUF_TWO;
          load_tail = '1;
        end else if (pop) begin
          lvl_d = OBUF_EMPTY;
        end
      end
      OBUF_TWO: begin
        if (pop) begin
          shift = '1;
          if (push) load_tail = '1;
          else      lvl_d     = OBUF_ONE;
        end
      end
      default: lvl_d = OBUF_EMPTY;
    endcase
    if (clear) begin
      lvl_d     = OBUF_EMPTY;
      load_head = '0;
      load_tail = '0;
      shift     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head)  head_q <= push_data;
      else if (shift) head_q <= tail_q;
      if (load_tail)  tail_q <= push_data;
    end
  end

  assign valid = (lvl_q != OBUF_EMPTY);
  assign head  = head_q;
  assign cnt   = lvl_q;

  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !clear && !pop && lvl_q == OBUF_TWO))
    else $error("%s", OBUF_OVF_MSG);

  assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !clear && lvl_q == OBUF_EMPTY))
    else $error("%s", OBUF_UDF_MSG);

endmodule

// File: rtl/sram_2rw_fifo_ctrl.sv
// FIFO controller over a 2RW SRAM macro (RW0 write-only, RW1 read-only) with a
// 2-entry output buffer that hides the 1-cycle read latency.
module sram_2rw_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter  int unsigned WIDTH  = 36,
  parameter  int unsigned DEPTH  = 32,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W  = count_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [WIDTH-1:0]  enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [WIDTH-1:0]  deq_bits,
  output logic [CNT_W-1:0]  count,
  output logic              mem_wr_clk,
  output logic              mem_rd_clk,
  output logic              mem_wr_en,
  output logic              mem_wr_wmode,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              mem_rd_en,
  output logic              mem_rd_wmode,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data
);

  localparam logic [ADDR_W:0] MEM_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   mem_used_q;
  logic              inflight_q;
  logic              enq_fire, deq_fire, rd_issue;
  logic [1:0]        obuf_cnt;
  logic [2:0]        obuf_after;

  assign enq_ready = (mem_used_q < MEM_FULL) && !flush;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready && !flush;

  // Read only when the buffer will still have a free slot once the pending
  // return lands, counting the slot this cycle's dequeue frees.
  assign obuf_after = 3'(obuf_cnt) + 3'(inflight_q) - 3'(deq_fire);
  assign rd_issue   = (mem_used_q > (ADDR_W+1)'(inflight_q)) && (obuf_after < 3'd2) && !flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_used_q <= '0;
      inflight_q <= '0;
    end else if (flush) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_used_q <= '0;
      inflight_q <= '0;
    end else begin
      if (enq_fire) wptr_q <= wptr_q + 1'b1;
      if (rd_issue) rptr_q <= rptr_q + 1'b1;
      inflight_q <= rd_issue;
      // SRAM slot is released on data return so a pending read address is never rewritten.
      mem_used_q <= mem_used_q + (ADDR_W+1)'(enq_fire) - (ADDR_W+1)'(inflight_q);
    end
  end

  sram_fifo_obuf #(
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk       (clock),
    .rst_n     (reset_n),
    .clear     (flush),
    .push      (inflight_q && !flush),
    .push_data (mem_rd_data),
    .pop       (deq_fire),
    .valid     (deq_valid),
    .head      (deq_bits),
    .cnt       (obuf_cnt)
  );

  assign count = CNT_W'(mem_used_q) + CNT_W'(obuf_cnt);

  assign mem_wr_clk   = clock;
  assign mem_rd_clk   = clock;
  assign mem_wr_en    = enq_fire;
  assign mem_wr_wmode = 1'b1;
  assign mem_wr_addr  = wptr_q;
  assign mem_wr_data  = enq_bits;
  assign mem_rd_en    = rd_issue;
  assign mem_rd_wmode = 1'b0;
  assign mem_rd_addr  = rptr_q;

endmodule
